// File: rtl/arith_pkg.sv
// Shared arithmetic types: serial subtractor state encoding and counter sizing helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Bit counter must hold 0..WIDTH.
    function automatic int sub_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell; purely combinational, zero latency, no flow control.
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first a-b-bin; done pulses WIDTH+1 cycles after start; start ignored while busy.
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int CNT_W = sub_cnt_width(WIDTH);

    sub_state_t       state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-2:0] diff_sh_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_d;
    logic [CNT_W-1:0] cnt_q;
    logic             c_q;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;
    logic             fa_s;
    logic             fa_co;
    logic             last_bit;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q;
    logic             b_msb_q;
    logic             ovf_q;
`endif

    // Subtraction as a + ~b + ~bin: the carry chain starts at ~bin.
    fulladder u_fa (
        .a_i (a_sh_q[0]),
        .b_i (~b_sh_q[0]),
        .c_i (c_q),
        .s_o (fa_s),
        .c_o (fa_co)
    );

    assign diff_d   = {fa_s, diff_sh_q};
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            diff_sh_q <= '0;
            diff_q    <= '0;
            cnt_q     <= '0;
            c_q       <= 1'b0;
            bout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        c_q     <= ~bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sh_q    <= a_sh_q >> 1;
                    b_sh_q    <= b_sh_q >> 1;
                    c_q       <= fa_co;
                    diff_sh_q <= diff_d[WIDTH-1:1];
                    cnt_q     <= cnt_q + CNT_W'(1);
                    // Visible result only changes once all bits are in.
                    if (last_bit) begin
                        diff_q  <= diff_d;
                        bout_q  <= ~fa_co;
                        done_q  <= 1'b1;
                        state_q <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q   <= (a_msb_q ^ b_msb_q) & (fa_s != a_msb_q);
`endif
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
